store_drain_unit: RTL and testbench
===================================

// Module: store_drain_unit
// PURPOSE
//  Commit-side drain for the speculative store buffer. Accepts stores retired by the ROB,
//  queues them in order, and writes them to data memory with byte enables over a req/ack
//  handshake. After each write completes it pulses a release (memwrite_rob/mem_addr_rob/
//  inst_num_rob) so the store buffer frees the matching entry. Flags loads hitting queued stores.
// PARAMETERS
//  DEPTH   8   queue entries, power of two, >=2
//  ADDR_W  32  address width
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high
//  commit_valid    in   1       ROB retires a store this cycle
//  commit_ready    out  1       queue can accept (= !full)
//  commit_addr     in   ADDR_W  byte address of store
//  commit_data     in   32      store data, right-aligned
//  commit_funct3   in   3       000 SB, 001 SH, 010 SW
//  commit_inst_num in   32      instruction number of store
//  dmem_req        out  1       write request, held until ack
//  dmem_ack        in   1       memory accepted write
//  dmem_addr       out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_wdata      out  32      lane-replicated write data
//  dmem_be         out  4       byte enables
//  memwrite_rob    out  1       1-cycle release pulse to store buffer
//  mem_addr_rob    out  ADDR_W  released store byte address
//  inst_num_rob    out  32      released store instruction number
//  load_chk_valid  in   1       load probing for conflict
//  load_chk_addr   in   ADDR_W  load byte address
//  load_conflict   out  1       load word matches a queued/in-flight store
//  misalign_err    out  1       1-cycle pulse: head entry misaligned/illegal, dropped
//  count           out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset: all outputs 0 except commit_ready=1; queue emptied, FSM->IDLE; in-flight req abandoned.
//  Push on commit_valid&&commit_ready; count visible next cycle. No push when full; push and
//   pop in the same cycle both take effect (count unchanged). Pointers wrap mod DEPTH.
//  FSM (registered outputs):
//   IDLE: count>0 -> CHECK next cycle.
//   CHECK: decode head. Legal -> REQ with dmem_* loaded. Illegal (SH addr[0]=1, SW addr[1:0]!=0,
//    funct3 not 000/001/010) -> pop, misalign_err=1 for one cycle, -> RELEASE (still released).
//   REQ: dmem_req=1, fields stable until ack. On ack: pop, dmem_req=0, -> RELEASE.
//   RELEASE: memwrite_rob=1 for exactly this cycle with head addr/inst_num; -> CHECK if count>0
//    else IDLE. mem_addr_rob/inst_num_rob hold last value otherwise.
//  Min latency: push at edge N -> dmem_req high from N+2 (IDLE->CHECK->REQ). Drain >=3 cycles/store.
//  Lane encode: SB be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; SH be=addr[1]?1100:0011,
//   wdata={2{d[15:0]}}; SW be=1111, wdata=d.
//  load_conflict: combinational; 1 iff load_chk_valid and any occupied entry (incl. in-flight
//   head until popped) has addr[ADDR_W-1:2]==load_chk_addr[ADDR_W-1:2]. Ignores be overlap.
//  No exception input: queued stores are architectural and never flushed.
//  dmem_ack outside REQ is ignored.
// STRUCTURE
//  Shared package: funct3 codes (F3_SB/SH/SW), FSM state enum, function be_wdata(funct3,addr,data).
//  Sub-module sdu_fifo: generic sync FIFO (DEPTH, WIDTH), exposes full/empty/count/head and all
//   entry addresses + valid bits for the conflict compare. FSM, encode, conflict logic at top.
// TESTING
//  SW 0x100, data 0xDEADBEEF, ack 1 cycle after req -> be=1111, wdata=DEADBEEF, then 1 release pulse addr 0x100.
//  SB 0x203 data 0x5A -> dmem_addr 0x200, be=1000, wdata=5A5A5A5A; SH 0x202 -> be=1100.
//  Fill 8 entries, hold ack=0 -> commit_ready=0, count=8; one ack -> ready=1, order preserved.
//  SW to 0x101 -> misalign_err pulse, no dmem_req, release pulse addr 0x101 issued.
//  Queue SW 0x300; probe load 0x302 -> load_conflict=1; after its release, probe -> 0.
//  Assert reset while dmem_req=1 -> next cycle dmem_req=0, count=0, no release pulse.

Source files
------------

// File: rtl/store_drain_unit_pkg.sv
// Shared definitions for the store drain unit: store size codes, drain FSM states,
// and the byte-lane encoder used to build memory write beats.
package store_drain_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_REQ     = 2'd2,
        S_RELEASE = 2'd3
    } sdu_state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } lane_t;

    function automatic logic store_legal(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_SB:   ok = 1'b1;
            F3_SH:   ok = ~addr_lo[0];
            F3_SW:   ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only meaningful for legal stores; illegal codes never reach the memory port.
    function automatic lane_t be_wdata(input logic [2:0]  funct3,
                                       input logic [1:0]  addr_lo,
                                       input logic [31:0] data);
        lane_t l;
        case (funct3)
            F3_SB: begin
                l.be    = 4'b0001 << addr_lo;
                l.wdata = {4{data[7:0]}};
            end
            F3_SH: begin
                l.be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                l.wdata = {2{data[15:0]}};
            end
            default: begin
                l.be    = 4'b1111;
                l.wdata = data;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/store_drain_unit_fifo.sv
// Generic synchronous FIFO; also exposes a key slice of every entry plus occupancy
// bits so the owner can do associative lookups across the whole queue.
module sdu_fifo #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 8,
    parameter int KEY_LSB = 0,
    parameter int KEY_W   = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [WIDTH-1:0]                   push_data,
    input  logic                               pop,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic [WIDTH-1:0]                   head,
    output logic [DEPTH-1:0][KEY_W-1:0]        keys,
    output logic [DEPTH-1:0]                   valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
            // Push and pop never target the same slot: that needs empty or full.
            if (do_pop)  valid[rd_ptr] <= 1'b0;
            if (do_push) valid[wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        keys = '0;
        for (int i = 0; i < DEPTH; i++) begin
            keys[i] = mem[i][KEY_LSB +: KEY_W];
        end
    end

endmodule

// File: rtl/store_drain_unit.sv
// Commit-side store drain: queues retired stores, writes them to data memory in order,
// then pulses a release so the store buffer can free the matching entry.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | queue empty, nothing to drain
//   S_CHECK   | decode head; load memory beat or drop an illegal store
//   S_REQ     | dmem_req held with stable fields until dmem_ack
//   S_RELEASE | one-cycle memwrite_rob pulse for the store just popped
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          commit_valid,
    output logic                          commit_ready,
    input  logic [ADDR_W-1:0]             commit_addr,
    input  logic [31:0]                   commit_data,
    input  logic [2:0]                    commit_funct3,
    input  logic [31:0]                   commit_inst_num,
    output logic                          dmem_req,
    input  logic                          dmem_ack,
    output logic [ADDR_W-1:0]             dmem_addr,
    output logic [31:0]                   dmem_wdata,
    output logic [3:0]                    dmem_be,
    output logic                          memwrite_rob,
    output logic [ADDR_W-1:0]             mem_addr_rob,
    output logic [31:0]                   inst_num_rob,
    input  logic                          load_chk_valid,
    input  logic [ADDR_W-1:0]             load_chk_addr,
    output logic                          load_conflict,
    output logic                          misalign_err,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    // Entry layout, LSB first: addr | data | funct3 | inst_num.
    localparam int EW    = ADDR_W + 32 + 3 + 32;
    localparam int KEY_W = ADDR_W - 2;

    sdu_state_t                   state;
    sdu_state_t                   state_nxt;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         pop;
    logic [EW-1:0]                head;
    logic [DEPTH-1:0][KEY_W-1:0]  fifo_keys;
    logic [DEPTH-1:0]             fifo_valid;
    logic [ADDR_W-1:0]            head_addr;
    logic [31:0]                  head_data;
    logic [2:0]                   head_funct3;
    logic [31:0]                  head_inst;
    logic                         head_legal;
    lane_t                        head_lane;

    sdu_fifo #(
        .DEPTH   (DEPTH),
        .WIDTH   (EW),
        .KEY_LSB (2),
        .KEY_W   (KEY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (commit_valid),
        .push_data ({commit_inst_num, commit_funct3, commit_data, commit_addr}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count),
        .head      (head),
        .keys      (fifo_keys),
        .valid     (fifo_valid)
    );

    assign commit_ready = !fifo_full;

    assign head_addr   = head[ADDR_W-1:0];
    assign head_data   = head[ADDR_W +: 32];
    assign head_funct3 = head[ADDR_W+32 +: 3];
    assign head_inst   = head[ADDR_W+35 +: 32];
    assign head_legal  = store_legal(head_funct3, head_addr[1:0]);
    assign head_lane   = be_wdata(head_funct3, head_addr[1:0], head_data);

    assign pop = ((state == S_CHECK) && !head_legal) || ((state == S_REQ) && dmem_ack);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (!fifo_empty) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = head_legal ? S_REQ : S_RELEASE;
            S_REQ:     if (dmem_ack) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = fifo_empty ? S_IDLE : S_CHECK;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_req     = (state == S_REQ);
        memwrite_rob = (state == S_RELEASE);
    end

    // Release fields are captured on the pop edge so they line up with the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            mem_addr_rob <= '0;
            inst_num_rob <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (state == S_CHECK) && !head_legal;
            if ((state == S_CHECK) && head_legal) begin
                dmem_addr  <= {head_addr[ADDR_W-1:2], 2'b00};
                dmem_be    <= head_lane.be;
                dmem_wdata <= head_lane.wdata;
            end
            if (pop) begin
                mem_addr_rob <= head_addr;
                inst_num_rob <= head_inst;
            end
        end
    end

    always_comb begin
        load_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (load_chk_valid && fifo_valid[i] &&
                (fifo_keys[i] == load_chk_addr[ADDR_W-1:2])) begin
                load_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_drain_unit.sv
// Bench for store_drain_unit: directed vector table, hand-written corner sequences,
// and a randomized phase checked cycle by cycle against a queue-based model.
module tb_store_drain_unit;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          commit_valid;
    logic                          commit_ready;
    logic [ADDR_W-1:0]             commit_addr;
    logic [31:0]                   commit_data;
    logic [2:0]                    commit_funct3;
    logic [31:0]                   commit_inst_num;
    logic                          dmem_req;
    logic                          dmem_ack;
    logic [ADDR_W-1:0]             dmem_addr;
    logic [31:0]                   dmem_wdata;
    logic [3:0]                    dmem_be;
    logic                          memwrite_rob;
    logic [ADDR_W-1:0]             mem_addr_rob;
    logic [31:0]                   inst_num_rob;
    logic                          load_chk_valid;
    logic [ADDR_W-1:0]             load_chk_addr;
    logic                          load_conflict;
    logic                          misalign_err;
    logic [$clog2(DEPTH+1)-1:0]    count;

    always #5 clk = ~clk;

    store_drain_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_ready    (commit_ready),
        .commit_addr     (commit_addr),
        .commit_data     (commit_data),
        .commit_funct3   (commit_funct3),
        .commit_inst_num (commit_inst_num),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .memwrite_rob    (memwrite_rob),
        .mem_addr_rob    (mem_addr_rob),
        .inst_num_rob    (inst_num_rob),
        .load_chk_valid  (load_chk_valid),
        .load_chk_addr   (load_chk_addr),
        .load_conflict   (load_conflict),
        .misalign_err    (misalign_err),
        .count           (count)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] data;
        logic [31:0] inst;
    } store_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] data;
        logic        exp_mis;
        logic [31:0] exp_daddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    store_t q[$];
    vec_t   vecs[9];

    function automatic vec_t mkv(string name, logic [31:0] addr, logic [2:0] f3, logic [31:0] data,
                                 logic exp_mis, logic [31:0] exp_daddr, logic [3:0] exp_be,
                                 logic [31:0] exp_wdata);
        vec_t v;
        v.name = name; v.addr = addr; v.f3 = f3; v.data = data;
        v.exp_mis = exp_mis; v.exp_daddr = exp_daddr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return (a % 2) == 0;
            3'd2:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d % 256) * 32'h0101_0101;
        if (f3 == 3'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit ref_conflict(input bit v, input logic [31:0] a);
        if (!v) return 1'b0;
        foreach (q[i]) if ((q[i].addr / 4) == (a / 4)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                              input logic [31:0] inst);
        commit_addr = a; commit_funct3 = f3; commit_data = d; commit_inst_num = inst;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic wait_req_or_mis(output int n);
        n = 0;
        while (!(dmem_req || misalign_err) && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic run_vector(input vec_t v, input logic [31:0] inst);
        int n;
        push_store(v.addr, v.f3, v.data, inst);
        wait_req_or_mis(n);
        if (n >= 12) begin
            timeout_fail({v.name, "_wait"});
            return;
        end
        check({v.name, "_latency"}, n, 2);
        check({v.name, "_misalign"}, misalign_err, v.exp_mis);
        if (v.exp_mis) begin
            check({v.name, "_noreq"}, dmem_req, 0);
            check({v.name, "_rel"}, memwrite_rob, 1);
            check({v.name, "_rel_addr"}, mem_addr_rob, v.addr);
            check({v.name, "_rel_inst"}, inst_num_rob, inst);
            tick();
            check({v.name, "_mis_end"}, misalign_err, 0);
            check({v.name, "_rel_end"}, memwrite_rob, 0);
        end else begin
            check({v.name, "_daddr"}, dmem_addr, v.exp_daddr);
            check({v.name, "_be"}, dmem_be, v.exp_be);
            check({v.name, "_wdata"}, dmem_wdata, v.exp_wdata);
            tick();
            check({v.name, "_req_hold"}, dmem_req, 1);
            check({v.name, "_be_hold"}, dmem_be, v.exp_be);
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
            check({v.name, "_req_drop"}, dmem_req, 0);
            check({v.name, "_rel"}, memwrite_rob, 1);
            check({v.name, "_rel_addr"}, mem_addr_rob, v.addr);
            check({v.name, "_rel_inst"}, inst_num_rob, inst);
            tick();
            check({v.name, "_rel_end"}, memwrite_rob, 0);
        end
    endtask

    // Serve the model's head store: optionally commit another store on the ack edge.
    task automatic serve_head(input string tag, input bit also_push, input store_t extra);
        int     n;
        store_t h;
        wait_req_or_mis(n);
        if (n >= 12 || !dmem_req || q.size() == 0) begin
            timeout_fail({tag, "_req"});
            return;
        end
        h = q[0];
        check({tag, "_daddr"}, dmem_addr, {h.addr[31:2], 2'b00});
        check({tag, "_be"}, dmem_be, ref_be(h.f3, h.addr));
        check({tag, "_wdata"}, dmem_wdata, ref_wdata(h.f3, h.data));
        if (also_push) begin
            commit_addr = extra.addr; commit_funct3 = extra.f3;
            commit_data = extra.data; commit_inst_num = extra.inst;
            commit_valid = 1'b1;
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        commit_valid = 1'b0;
        void'(q.pop_front());
        if (also_push) q.push_back(extra);
        check({tag, "_count"}, count, q.size());
        check({tag, "_rel"}, memwrite_rob, 1);
        check({tag, "_rel_addr"}, mem_addr_rob, h.addr);
        check({tag, "_rel_inst"}, inst_num_rob, h.inst);
    endtask

    initial begin
        store_t s, pend, rel, none;
        int     n;
        bit     push_prev, ack_prev, expect_rel;
        int     stall;
        logic [31:0] inst_ctr;

        vecs[0] = mkv("sw_100",   32'h100,  3'b010, 32'hDEADBEEF, 0, 32'h100,  4'b1111, 32'hDEADBEEF);
        vecs[1] = mkv("sb_203",   32'h203,  3'b000, 32'h0000005A, 0, 32'h200,  4'b1000, 32'h5A5A5A5A);
        vecs[2] = mkv("sh_202",   32'h202,  3'b001, 32'h00001234, 0, 32'h200,  4'b1100, 32'h12341234);
        vecs[3] = mkv("sb_200",   32'h200,  3'b000, 32'hFFFFFF11, 0, 32'h200,  4'b0001, 32'h11111111);
        vecs[4] = mkv("sh_200",   32'h200,  3'b001, 32'h1234CAFE, 0, 32'h200,  4'b0011, 32'hCAFECAFE);
        vecs[5] = mkv("sw_101",   32'h101,  3'b010, 32'h01234567, 1, 32'h0,    4'b0000, 32'h0);
        vecs[6] = mkv("sh_203",   32'h203,  3'b001, 32'h0000BEEF, 1, 32'h0,    4'b0000, 32'h0);
        vecs[7] = mkv("f3_011",   32'h400,  3'b011, 32'h89ABCDEF, 1, 32'h0,    4'b0000, 32'h0);
        vecs[8] = mkv("sb_1001",  32'h1001, 3'b000, 32'hABCDEF77, 0, 32'h1000, 4'b0010, 32'h77777777);
        none = '{addr: 32'h0, f3: 3'b0, data: 32'h0, inst: 32'h0};

        reset = 1'b1;
        commit_valid = 1'b0; commit_addr = '0; commit_data = '0; commit_funct3 = '0;
        commit_inst_num = '0; dmem_ack = 1'b0; load_chk_valid = 1'b0; load_chk_addr = '0;
        repeat (3) tick();
        check("rst_ready", commit_ready, 1);
        check("rst_count", count, 0);
        check("rst_req", dmem_req, 0);
        check("rst_rel", memwrite_rob, 0);
        check("rst_mis", misalign_err, 0);
        check("rst_conflict", load_conflict, 0);
        check("rst_daddr", dmem_addr, 0);
        check("rst_be", dmem_be, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_rel_addr", mem_addr_rob, 0);
        check("rst_rel_inst", inst_num_rob, 0);
        reset = 1'b0;
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("idle_ack_ignored", memwrite_rob, 0);

        for (int i = 0; i < 9; i++) run_vector(vecs[i], 32'(10 + i));

        // Load conflict against a queued and then in-flight store, cleared after release.
        push_store(32'h300, 3'b010, 32'h11223344, 32'd50);
        load_chk_valid = 1'b1; load_chk_addr = 32'h302;
        #1 check("conf_queued", load_conflict, 1);
        load_chk_addr = 32'h304;
        #1 check("conf_other_word", load_conflict, 0);
        load_chk_addr = 32'h302;
        q.push_back('{addr: 32'h300, f3: 3'b010, data: 32'h11223344, inst: 32'd50});
        wait_req_or_mis(n);
        #1 check("conf_inflight", load_conflict, 1);
        serve_head("conf", 1'b0, none);
        #1 check("conf_after_release", load_conflict, 0);
        load_chk_valid = 1'b0;
        repeat (2) tick();

        // Fill with the memory stalled, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            s = '{addr: 32'h1000 + 32'(4 * i), f3: 3'b010, data: 32'h1111_1111 * 32'(i + 1),
                  inst: 32'(100 + i)};
            push_store(s.addr, s.f3, s.data, s.inst);
            q.push_back(s);
        end
        check("full_count", count, DEPTH);
        check("full_ready", commit_ready, 0);
        push_store(32'h9990, 3'b010, 32'h0, 32'd999);
        check("full_no_push", count, DEPTH);
        check("full_req", dmem_req, 1);
        load_chk_valid = 1'b1; load_chk_addr = 32'h100A;
        #1 check("full_conf_mid", load_conflict, 1);
        load_chk_addr = 32'h2000;
        #1 check("full_conf_miss", load_conflict, 0);
        load_chk_valid = 1'b0; load_chk_addr = 32'h1000;
        #1 check("full_conf_novalid", load_conflict, 0);
        serve_head("fill0", 1'b0, none);
        check("fill0_ready", commit_ready, 1);
        s = '{addr: 32'h1020, f3: 3'b000, data: 32'h000000C3, inst: 32'd108};
        serve_head("fill1_pushpop", 1'b1, s);
        n = 0;
        while (q.size() > 0 && n < 20) begin
            serve_head("fill_drain", 1'b0, none);
            n++;
        end
        repeat (3) tick();
        check("fill_empty", count, 0);

        // Randomized traffic against the queue model.
        push_prev = 0; ack_prev = 0; stall = 0; inst_ctr = 32'd1000;
        pend = none; rel = none;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            expect_rel = 0;
            if (ack_prev && q.size() > 0) begin
                rel = q.pop_front();
                expect_rel = 1;
            end
            if (misalign_err) begin
                check("rnd_mis_head_illegal", (q.size() > 0) && !ref_legal(q[0].f3, q[0].addr), 1);
                if (q.size() > 0) begin
                    rel = q.pop_front();
                    expect_rel = 1;
                end
            end
            if (push_prev) q.push_back(pend);
            if (expect_rel || q.size() == 0) stall = 0;
            else stall++;
            if (stall > 40) begin
                timeout_fail("rnd_progress");
                break;
            end
            check("rnd_count", count, q.size());
            check("rnd_ready", commit_ready, q.size() < DEPTH);
            check("rnd_rel", memwrite_rob, expect_rel);
            if (expect_rel && memwrite_rob) begin
                check("rnd_rel_addr", mem_addr_rob, rel.addr);
                check("rnd_rel_inst", inst_num_rob, rel.inst);
            end
            if (dmem_req) begin
                if (q.size() == 0) timeout_fail("rnd_req_empty");
                else begin
                    check("rnd_req_legal", ref_legal(q[0].f3, q[0].addr), 1);
                    check("rnd_daddr", dmem_addr, {q[0].addr[31:2], 2'b00});
                    check("rnd_be", dmem_be, ref_be(q[0].f3, q[0].addr));
                    check("rnd_wdata", dmem_wdata, ref_wdata(q[0].f3, q[0].data));
                end
            end
            pend.addr = 32'h2000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            pend.f3   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            pend.data = $urandom;
            pend.inst = inst_ctr;
            inst_ctr++;
            commit_valid = ($urandom_range(0, 9) < 6);
            commit_addr = pend.addr; commit_funct3 = pend.f3;
            commit_data = pend.data; commit_inst_num = pend.inst;
            push_prev = commit_valid && (q.size() < DEPTH);
            dmem_ack = dmem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            ack_prev = dmem_ack && dmem_req;
            load_chk_valid = ($urandom_range(0, 3) != 0);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                load_chk_addr = {q[$urandom_range(0, q.size() - 1)].addr[31:2], 2'($urandom_range(0, 3))};
            else
                load_chk_addr = 32'h2000 + 32'($urandom_range(0, 80));
            #1;
            check("rnd_conflict", load_conflict, ref_conflict(load_chk_valid, load_chk_addr));
            @(posedge clk);
            #1;
        end
        commit_valid = 1'b0; dmem_ack = 1'b0; load_chk_valid = 1'b0;

        // Reset while a write request is outstanding.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        tick();
        push_store(32'h500, 3'b010, 32'hCAFEF00D, 32'd77);
        wait_req_or_mis(n);
        if (n >= 12) timeout_fail("rstreq_wait");
        check("rstreq_req_before", dmem_req, 1);
        reset = 1'b1;
        tick();
        check("rstreq_req", dmem_req, 0);
        check("rstreq_count", count, 0);
        check("rstreq_rel", memwrite_rob, 0);
        check("rstreq_ready", commit_ready, 1);
        reset = 1'b0;
        tick();
        check("rstreq_rel_after", memwrite_rob, 0);
        check("rstreq_req_after", dmem_req, 0);
        tick();
        check("rstreq_idle_rel", memwrite_rob, 0);
        check("rstreq_idle_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
